// File: rtl/mem_copy_dma.sv
// mem_copy_dma: memory-bus initiator that copies a block of words from a source
// address to a destination address, one word at a time (read, read, write).
// It requests the shared bus through a bus_req/bus_gnt pair and uses the same
// mem_cmd/mem_addr/write_data/read_data protocol as the CPU.
module mem_copy_dma #(
  parameter int AW = 9,
  parameter int DW = 16,
  parameter int LW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] dst_addr,
  input  logic [LW-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          bus_req,
  input  logic          bus_gnt,
  output logic [1:0]    mem_cmd,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] write_data,
  input  logic [DW-1:0] read_data
);

  localparam logic [1:0] MNONE  = 2'b00;
  localparam logic [1:0] MREAD  = 2'b01;
  localparam logic [1:0] MWRITE = 2'b10;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    RD1  = 3'd2,
    RD2  = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_ptr_q, src_ptr_d;
  logic [AW-1:0] dst_ptr_q, dst_ptr_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] data_reg_q, data_reg_d;

  // State, pointers, remaining word count and the captured data word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      src_ptr_q  <= '0;
      dst_ptr_q  <= '0;
      cnt_q      <= '0;
      data_reg_q <= '0;
    end else begin
      state_q    <= state_d;
      src_ptr_q  <= src_ptr_d;
      dst_ptr_q  <= dst_ptr_d;
      cnt_q      <= cnt_d;
      data_reg_q <= data_reg_d;
    end
  end

  // Next-state and datapath updates; pointers wrap naturally modulo 2^AW.
  always_comb begin
    state_d    = state_q;
    src_ptr_d  = src_ptr_q;
    dst_ptr_d  = dst_ptr_q;
    cnt_d      = cnt_q;
    data_reg_d = data_reg_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          src_ptr_d = src_addr;
          dst_ptr_d = dst_addr;
          cnt_d     = len;
          state_d   = (len == '0) ? DONE : REQ;
        end
      end
      REQ: begin
        if (bus_gnt) begin
          state_d = RD1;
        end
      end
      RD1: begin
        state_d = RD2;
      end
      RD2: begin
        data_reg_d = read_data;
        state_d    = WR;
      end
      WR: begin
        src_ptr_d = src_ptr_q + AW'(1);
        dst_ptr_d = dst_ptr_q + AW'(1);
        cnt_d     = cnt_q - LW'(1);
        if (cnt_q == LW'(1)) begin
          state_d = DONE;
        end else if (bus_gnt) begin
          state_d = RD1;
        end else begin
          state_d = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Bus and status outputs decoded from the current state; the bus is idle
  // (MNONE, zero address and data) outside the read and write states.
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    bus_req    = 1'b0;
    mem_cmd    = MNONE;
    mem_addr   = '0;
    write_data = '0;
    case (state_q)
      REQ: begin
        busy    = 1'b1;
        bus_req = 1'b1;
      end
      RD1: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        mem_cmd  = MREAD;
        mem_addr = src_ptr_q;
      end
      RD2: begin
        busy     = 1'b1;
        bus_req  = 1'b1;
        mem_cmd  = MREAD;
        mem_addr = src_ptr_q;
      end
      WR: begin
        busy       = 1'b1;
        bus_req    = 1'b1;
        mem_cmd    = MWRITE;
        mem_addr   = dst_ptr_q;
        write_data = data_reg_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_copy_dma.sv
// tb_mem_copy_dma: directed bench for mem_copy_dma with a synchronous-read RAM
// model on the bus and a queue of expected bus cycles.
module tb_mem_copy_dma;

  localparam int AW = 9;
  localparam int DW = 16;
  localparam int LW = 8;

  logic          clk;
  logic          reset;
  logic          start;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic [LW-1:0] len;
  logic          busy;
  logic          done;
  logic          bus_req;
  logic          bus_gnt;
  logic [1:0]    mem_cmd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data;

  logic          bd_we;
  logic [AW-1:0] bd_addr;
  logic [DW-1:0] bd_data;
  logic [DW-1:0] ram [0:511];

  typedef struct packed {
    logic [1:0]    cmd;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_txn_t;

  bus_txn_t exp_q[$];
  int errors;
  int checks;

  mem_copy_dma #(.AW(AW), .DW(DW), .LW(LW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_addr   (src_addr),
    .dst_addr   (dst_addr),
    .len        (len),
    .busy       (busy),
    .done       (done),
    .bus_req    (bus_req),
    .bus_gnt    (bus_gnt),
    .mem_cmd    (mem_cmd),
    .mem_addr   (mem_addr),
    .write_data (write_data),
    .read_data  (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM on the bus, plus a backdoor port for preloading.
  always @(posedge clk) begin
    if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end else if (mem_cmd == 2'b10) begin
      ram[mem_addr] <= write_data;
    end
    if (mem_cmd == 2'b01) begin
      read_data <= ram[mem_addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Compare any active bus cycle against the next expected one.
  task automatic monitorBus();
    bus_txn_t e;
    if (mem_cmd != 2'b00) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("[TB] FAIL unexpected_bus: observed cmd=%0h addr=%0h expected=none",
               mem_cmd, mem_addr);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checkOutput("bus_cmd", 32'(mem_cmd), 32'(e.cmd));
        checkOutput("bus_addr", 32'(mem_addr), 32'(e.addr));
        if (e.cmd == 2'b10) begin
          checkOutput("bus_wdata", 32'(write_data), 32'(e.data));
        end
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    monitorBus();
    @(posedge clk);
    #1;
  endtask

  task automatic loadWord(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we   = 1'b1;
    bd_addr = a;
    bd_data = d;
    tick();
    bd_we   = 1'b0;
  endtask

  task automatic pushWord(input logic [AW-1:0] s, input logic [AW-1:0] d,
                          input logic [DW-1:0] v);
    exp_q.push_back('{cmd: 2'b01, addr: s, data: '0});
    exp_q.push_back('{cmd: 2'b01, addr: s, data: '0});
    exp_q.push_back('{cmd: 2'b10, addr: d, data: v});
  endtask

  task automatic applyStimulus(input logic [AW-1:0] s, input logic [AW-1:0] d,
                               input logic [LW-1:0] n);
    start    = 1'b1;
    src_addr = s;
    dst_addr = d;
    len      = n;
    tick();
    start    = 1'b0;
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_req"}, 32'(bus_req), 32'd0);
    checkOutput({tag, "_cmd"}, 32'(mem_cmd), 32'd0);
    checkOutput({tag, "_addr"}, 32'(mem_addr), 32'd0);
    checkOutput({tag, "_wdata"}, 32'(write_data), 32'd0);
  endtask

  // Counts clock edges after the start-sampling edge until done is seen.
  task automatic waitDone(input string tag, input int limit, output int edges);
    edges = 0;
    while (!done && edges < limit) begin
      tick();
      edges++;
    end
    checkOutput({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  initial begin
    int edges;
    int reads;
    int guard;
    errors   = 0;
    checks   = 0;
    reset    = 1'b0;
    start    = 1'b0;
    bus_gnt  = 1'b0;
    src_addr = '0;
    dst_addr = '0;
    len      = '0;
    bd_we    = 1'b0;
    bd_addr  = '0;
    bd_data  = '0;

    // Reset held with random inputs, then released.
    repeat (6) begin
      start    = 1'($urandom);
      bus_gnt  = 1'($urandom);
      src_addr = AW'($urandom);
      dst_addr = AW'($urandom);
      len      = LW'($urandom);
      tick();
      checkIdle("reset");
    end
    start   = 1'b0;
    bus_gnt = 1'b0;
    reset   = 1'b1;
    tick();
    checkIdle("after_reset");

    // Basic three-word copy with the grant held.
    loadWord(9'h010, 16'hA001);
    loadWord(9'h011, 16'hA002);
    loadWord(9'h012, 16'hA003);
    bus_gnt = 1'b1;
    pushWord(9'h010, 9'h040, 16'hA001);
    pushWord(9'h011, 9'h041, 16'hA002);
    pushWord(9'h012, 9'h042, 16'hA003);
    applyStimulus(9'h010, 9'h040, 8'd3);
    checkOutput("copy_busy", 32'(busy), 32'd1);
    checkOutput("copy_req", 32'(bus_req), 32'd1);
    waitDone("copy", 40, edges);
    checkOutput("copy_latency", 32'(edges), 32'd10);
    checkOutput("copy_done_busy", 32'(busy), 32'd0);
    tick();
    checkOutput("copy_done_pulse", 32'(done), 32'd0);
    checkOutput("copy_ram40", 32'(ram[9'h040]), 32'hA001);
    checkOutput("copy_ram41", 32'(ram[9'h041]), 32'hA002);
    checkOutput("copy_ram42", 32'(ram[9'h042]), 32'hA003);
    checkOutput("copy_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero length completes at once without touching the bus.
    applyStimulus(9'h080, 9'h090, 8'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    checkOutput("zero_req", 32'(bus_req), 32'd0);
    checkOutput("zero_cmd", 32'(mem_cmd), 32'd0);
    tick();
    checkIdle("zero_after");

    // Address wrap at the top of the address space.
    loadWord(9'h1FF, 16'hB1FF);
    loadWord(9'h000, 16'hB000);
    pushWord(9'h1FF, 9'h0FE, 16'hB1FF);
    pushWord(9'h000, 9'h0FF, 16'hB000);
    applyStimulus(9'h1FF, 9'h0FE, 8'd2);
    waitDone("wrap", 40, edges);
    checkOutput("wrap_latency", 32'(edges), 32'd7);
    tick();
    checkOutput("wrap_ramfe", 32'(ram[9'h0FE]), 32'hB1FF);
    checkOutput("wrap_ramff", 32'(ram[9'h0FF]), 32'hB000);
    checkOutput("wrap_sb_empty", 32'(exp_q.size()), 32'd0);

    // Grant stall at start, then grant removed after the first word.
    bus_gnt = 1'b0;
    loadWord(9'h020, 16'hC001);
    loadWord(9'h021, 16'hC002);
    loadWord(9'h022, 16'hC003);
    pushWord(9'h020, 9'h060, 16'hC001);
    pushWord(9'h021, 9'h061, 16'hC002);
    pushWord(9'h022, 9'h062, 16'hC003);
    applyStimulus(9'h020, 9'h060, 8'd3);
    repeat (5) begin
      checkOutput("stall_req", 32'(bus_req), 32'd1);
      checkOutput("stall_cmd", 32'(mem_cmd), 32'd0);
      checkOutput("stall_busy", 32'(busy), 32'd1);
      tick();
    end
    bus_gnt = 1'b1;
    guard = 0;
    while (mem_cmd != 2'b10 && guard < 10) begin
      tick();
      guard++;
    end
    checkOutput("stall_wr1_seen", 32'(mem_cmd), 32'h2);
    bus_gnt = 1'b0;
    tick();
    checkOutput("regrant_cmd", 32'(mem_cmd), 32'd0);
    checkOutput("regrant_req", 32'(bus_req), 32'd1);
    tick();
    tick();
    checkOutput("regrant_hold_cmd", 32'(mem_cmd), 32'd0);
    bus_gnt = 1'b1;
    waitDone("stall", 40, edges);
    tick();
    checkOutput("stall_ram60", 32'(ram[9'h060]), 32'hC001);
    checkOutput("stall_ram61", 32'(ram[9'h061]), 32'hC002);
    checkOutput("stall_ram62", 32'(ram[9'h062]), 32'hC003);
    checkOutput("stall_sb_empty", 32'(exp_q.size()), 32'd0);

    // Reset during the second read cycle of word 2; a stray start mid-copy.
    loadWord(9'h030, 16'hD001);
    loadWord(9'h031, 16'hD002);
    loadWord(9'h032, 16'hD003);
    loadWord(9'h070, 16'h0000);
    loadWord(9'h071, 16'h0000);
    loadWord(9'h072, 16'h0000);
    pushWord(9'h030, 9'h070, 16'hD001);
    exp_q.push_back('{cmd: 2'b01, addr: 9'h031, data: '0});
    applyStimulus(9'h030, 9'h070, 8'd3);
    reads = 0;
    guard = 0;
    while (reads < 4 && guard < 30) begin
      tick();
      guard++;
      start = 1'b0;
      if (mem_cmd == 2'b01) begin
        reads++;
        if (reads == 1) begin
          start    = 1'b1;
          src_addr = 9'h100;
          dst_addr = 9'h150;
          len      = 8'd5;
        end
      end
    end
    checkOutput("midrst_rd2_reached", 32'(reads), 32'd4);
    checkOutput("midrst_pre_addr", 32'(mem_addr), 32'h031);
    reset = 1'b0;
    #1;
    checkIdle("midrst");
    tick();
    tick();
    reset = 1'b1;
    tick();
    checkIdle("midrst_after");
    checkOutput("midrst_ram70", 32'(ram[9'h070]), 32'hD001);
    checkOutput("midrst_ram71", 32'(ram[9'h071]), 32'h0000);
    checkOutput("midrst_ram72", 32'(ram[9'h072]), 32'h0000);
    checkOutput("midrst_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
